fasta_to_sam_fsm: RTL and testbench

- Streaming converter that reads FASTA text, one byte per address, from a synchronous single-port ROM.
- Writes the equivalent unmapped-read SAM text, one byte per write, into a single-port RAM.
- Sits between the FASTA ROM (blk_mem_gen_1) and the SAM RAM (blk_mem_gen_0); both memories share its clock.
- Runs once after reset and then raises done.

---
 rtl/fasta_to_sam_fsm.sv | 186 ++++++++++++++++++
 tb/tb_fasta_to_sam_fsm.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fasta_to_sam_fsm.sv
// FASTA-to-SAM streaming converter.
// Reads FASTA bytes from a registered-read ROM and writes unmapped-read SAM
// records into a RAM. It runs once after reset, then holds done high.
module fasta_to_sam_fsm #(
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [7:0]            rom_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]            ram_data,
  output logic                  ram_we,
  output logic                  done
);

  localparam logic [7:0] CH_NUL  = 8'h00;
  localparam logic [7:0] CH_TAB  = 8'h09;
  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_SP   = 8'h20;
  localparam logic [7:0] CH_STAR = 8'h2A;
  localparam logic [7:0] CH_GT   = 8'h3E;

  typedef enum logic [2:0] {SEEK, NAME, SKIPHDR, MID, SEQ, TAIL, FINISH} state_t;

  state_t                state, state_n;
  logic [1:0]            phase;       // 0: address issued, 1: wait, 2: use rom_data
  logic                  eof;         // last ROM address already consumed
  logic                  name_empty;
  logic                  seq_empty;
  logic                  line_start;
  logic                  fin_pending; // input terminated; close record then finish
  logic [4:0]            idx;         // index into the constant MID/TAIL strings
  logic [ADDR_WIDTH-1:0] wr_ptr;

  logic                  reading, byte_ok, is_term, is_delim;
  logic                  wr_req;
  logic [7:0]            wr_byte;

  // Fixed middle string: even positions are TAB, odd positions carry the fields.
  function automatic logic [7:0] mid_byte(input logic [4:0] i);
    logic [7:0] b;
    b = CH_TAB;
    case (i)
      5'd1:                               b = 8'h34;   // '4'
      5'd3, 5'd9, 5'd11:                  b = CH_STAR;
      5'd5, 5'd7, 5'd13, 5'd15:           b = 8'h30;   // '0'
      default:                            b = CH_TAB;
    endcase
    return b;
  endfunction

  // Tail string "*\t*\n"; index 0 (the '*') is only used when SEQ is empty.
  function automatic logic [7:0] tail_byte(input logic [4:0] i);
    logic [7:0] b;
    case (i)
      5'd0:    b = CH_STAR;
      5'd1:    b = CH_TAB;
      5'd2:    b = CH_STAR;
      default: b = CH_LF;
    endcase
    return b;
  endfunction

  function automatic logic [7:0] upcase(input logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
  endfunction

  assign reading  = (state == SEEK) || (state == NAME) || (state == SKIPHDR) || (state == SEQ);
  assign byte_ok  = reading && (phase == 2'd2) && !eof;
  assign is_term  = reading && (eof || (byte_ok && rom_data == CH_NUL));
  assign is_delim = (rom_data == CH_SP) || (rom_data == CH_TAB) ||
                    (rom_data == CH_CR) || (rom_data == CH_LF);

  // Output decode: which byte, if any, is written this cycle.
  always_comb begin
    wr_req  = 1'b0;
    wr_byte = '0;
    case (state)
      NAME: begin
        if (is_term || (byte_ok && is_delim)) begin
          wr_req  = name_empty;
          wr_byte = CH_STAR;
        end else if (byte_ok) begin
          wr_req  = 1'b1;
          wr_byte = rom_data;
        end
      end
      MID: begin
        wr_req  = 1'b1;
        wr_byte = mid_byte(idx);
      end
      SEQ: begin
        if (byte_ok && !is_term && !(rom_data == CH_GT && line_start) &&
            rom_data != CH_CR && rom_data != CH_LF) begin
          wr_req  = 1'b1;
          wr_byte = upcase(rom_data);
        end
      end
      TAIL: begin
        wr_req  = 1'b1;
        wr_byte = tail_byte(idx);
      end
      default: ;
    endcase
  end

  // Next-state decode; filling the last RAM address overrides everything.
  always_comb begin
    state_n = state;
    case (state)
      SEEK:    if (is_term) state_n = FINISH;
               else if (byte_ok && rom_data == CH_GT) state_n = NAME;
      NAME:    if (is_term) state_n = MID;
               else if (byte_ok && rom_data == CH_LF) state_n = MID;
               else if (byte_ok && is_delim) state_n = SKIPHDR;
      SKIPHDR: if (is_term || (byte_ok && rom_data == CH_LF)) state_n = MID;
      MID:     if (idx == 5'd16) state_n = fin_pending ? TAIL : SEQ;
      SEQ:     if (is_term || (byte_ok && rom_data == CH_GT && line_start)) state_n = TAIL;
      TAIL:    if (idx == 5'd3) state_n = fin_pending ? FINISH : NAME;
      default: state_n = FINISH;
    endcase
    if (wr_req && wr_ptr == '1) state_n = FINISH;
  end

  // State register, read sequencing, record bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SEEK;
      phase       <= '0;
      eof         <= 1'b0;
      name_empty  <= 1'b1;
      seq_empty   <= 1'b1;
      line_start  <= 1'b1;
      fin_pending <= 1'b0;
      idx         <= '0;
      wr_ptr      <= '0;
      rom_addr    <= '0;
      ram_addr    <= '0;
      ram_data    <= '0;
      ram_we      <= 1'b0;
      done        <= 1'b0;
    end else begin
      state <= state_n;

      if (!reading || state_n != state || phase == 2'd2) phase <= '0;
      else                                               phase <= phase + 2'd1;

      // Advance past consumed bytes; the terminator byte itself is not skipped.
      if (byte_ok && rom_data != CH_NUL && state_n != FINISH) begin
        if (rom_addr == '1) eof <= 1'b1;
        else                rom_addr <= rom_addr + 1'b1;
      end

      if (is_term && state != SEEK) fin_pending <= 1'b1;

      if (state_n == NAME && state != NAME) name_empty <= 1'b1;
      else if (state == NAME && wr_req)     name_empty <= 1'b0;

      if (state == NAME)                seq_empty <= 1'b1;
      else if (state == SEQ && wr_req)  seq_empty <= 1'b0;

      // CR leaves the line-start flag alone so CRLF endings behave like LF.
      if (state == MID) line_start <= 1'b1;
      else if (state == SEQ && byte_ok && rom_data != CH_CR)
        line_start <= (rom_data == CH_LF);

      if (state_n == TAIL && state != TAIL) idx <= seq_empty ? 5'd0 : 5'd1;
      else if (state == MID || state == TAIL) idx <= idx + 5'd1;
      else idx <= '0;

      if (wr_req) begin
        ram_we   <= 1'b1;
        ram_addr <= wr_ptr;
        ram_data <= wr_byte;
        wr_ptr   <= wr_ptr + 1'b1;
      end else begin
        ram_we <= 1'b0;
      end

      done <= (state_n == FINISH);
    end
  end

endmodule

// File: tb/tb_fasta_to_sam_fsm.sv
// Scoreboard bench for fasta_to_sam_fsm using a reduced address width.
// A text-level FASTA parser produces the expected SAM byte stream.
module tb_fasta_to_sam_fsm;

  localparam int AW = 10;
  localparam int SZ = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] rom_addr, ram_addr;
  logic [7:0]    rom_data = '0;
  logic [7:0]    ram_data;
  logic          ram_we, done;

  logic [7:0] rom [0:SZ-1];

  typedef struct {
    int unsigned addr;
    logic [7:0]  data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  writes = 0;

  always #5 clk = ~clk;

  // Registered-read ROM.
  always @(posedge clk) rom_data <= rom[rom_addr];

  fasta_to_sam_fsm #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .done(done)
  );

  // Monitor: every write is checked against the head of the expected queue.
  always begin
    wr_t e;
    @(posedge clk);
    #1;
    if (ram_we) begin
      writes++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_extra: got addr=%0d data=%02h, required no write", ram_addr, ram_data);
      end else begin
        e = exp_q.pop_front();
        if (ram_addr !== e.addr[AW-1:0] || ram_data !== e.data) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                   ram_addr, ram_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, actual, required);
    end
  endtask

  function automatic bit is_delim(input logic [7:0] c);
    return c == 8'h20 || c == 8'h09 || c == 8'h0D || c == 8'h0A;
  endfunction

  // Reference: parse the ROM image as text into records, then render SAM lines.
  function automatic void model_push();
    logic [7:0] out_q[$];
    logic [7:0] name_q[$];
    logic [7:0] seq_q[$];
    logic [7:0] c;
    string mid = "\t4\t*\t0\t0\t*\t*\t0\t0\t";
    string tl  = "\t*\n";
    int n = 0;
    int p = 0;
    bit ls;
    wr_t w;
    while (n < SZ && rom[n] != 8'h00) n++;
    while (p < n && rom[p] != ">") p++;
    while (p < n) begin
      p++;
      name_q.delete();
      seq_q.delete();
      while (p < n && !is_delim(rom[p])) begin name_q.push_back(rom[p]); p++; end
      while (p < n && rom[p] != 8'h0A) p++;
      if (p < n) p++;
      ls = 1'b1;
      while (p < n && !(rom[p] == ">" && ls)) begin
        c = rom[p];
        if (c == 8'h0A) ls = 1'b1;
        else if (c != 8'h0D) ls = 1'b0;
        if (c != 8'h0D && c != 8'h0A)
          seq_q.push_back((c >= "a" && c <= "z") ? c - 8'h20 : c);
        p++;
      end
      if (name_q.size() == 0) out_q.push_back("*");
      foreach (name_q[i]) out_q.push_back(name_q[i]);
      for (int i = 0; i < mid.len(); i++) out_q.push_back(mid[i]);
      if (seq_q.size() == 0) out_q.push_back("*");
      foreach (seq_q[i]) out_q.push_back(seq_q[i]);
      for (int i = 0; i < tl.len(); i++) out_q.push_back(tl[i]);
    end
    exp_q.delete();
    for (int i = 0; i < out_q.size() && i < SZ; i++) begin
      w.addr = i;
      w.data = out_q[i];
      exp_q.push_back(w);
    end
  endfunction

  task automatic load_str(input string s);
    for (int i = 0; i < SZ; i++) rom[i] = 8'h00;
    for (int i = 0; i < s.len(); i++) rom[i] = s[i];
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rom_addr"}, int'(rom_addr), 0);
    chk({tag, "_ram_addr"}, int'(ram_addr), 0);
    chk({tag, "_ram_data"}, int'(ram_data), 0);
    chk({tag, "_ram_we"},   int'(ram_we),   0);
    chk({tag, "_done"},     int'(done),     0);
  endtask

  task automatic start(input string tag);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values(tag);
    @(negedge clk);
    model_push();
    writes = 0;
    rst = 1'b0;
  endtask

  task automatic finish_check(input string tag, input int nexp, input int budget);
    int cyc = 0;
    int bad = 0;
    while (!done && cyc < budget) begin @(negedge clk); cyc++; end
    chk({tag, "_done"}, int'(done), 1);
    @(negedge clk);
    chk({tag, "_writes"}, writes, nexp);
    chk({tag, "_pending"}, exp_q.size(), 0);
    repeat (12) begin
      @(negedge clk);
      if (ram_we || !done) bad++;
    end
    chk({tag, "_idle_after_done"}, bad, 0);
  endtask

  task automatic run(input string tag, input int budget);
    int nexp;
    start(tag);
    nexp = exp_q.size();
    finish_check(tag, nexp, budget);
  endtask

  initial begin
    string alpha = "ACGTacgtN>>\n\n\r x";
    int nexp;
    int cyc;
    int n;

    load_str(">r1\nACGT\n");
    run("basic", 2000);

    load_str(">a desc\nac\ngT\n>b\nTT");
    run("two_rec", 2000);

    load_str(">x\n>\nA");
    run("empty_fields", 2000);

    load_str("junk\n>q\r\nN\r\n");
    run("crlf", 2000);

    // Reset after the 5th write; the rerun must restart from address 0.
    load_str(">r1\nACGT\n");
    start("rst_pre");
    cyc = 0;
    while (writes < 5 && cyc < 500) begin @(negedge clk); cyc++; end
    chk("rst_fifth_write_seen", writes, 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values("rst_mid");
    @(negedge clk);
    model_push();
    nexp = exp_q.size();
    writes = 0;
    rst = 1'b0;
    finish_check("rst_rerun", nexp, 2000);

    // No terminator: RAM fills and writing stops at the last address.
    load_str(">r\n");
    for (int i = 3; i < SZ; i++) rom[i] = "A";
    run("ram_full", 6000);

    // No terminator: the final ROM byte closes the record.
    load_str(">r\n");
    for (int i = 3; i < SZ - 2; i++) rom[i] = 8'h0A;
    rom[SZ-2] = "a";
    rom[SZ-1] = "c";
    run("rom_end", 6000);

    // Junk only, no terminator: no writes at all.
    for (int i = 0; i < SZ; i++) rom[i] = "j";
    run("rom_end_junk", 6000);

    for (int r = 0; r < 8; r++) begin
      load_str("");
      n = $urandom_range(20, 160);
      rom[0] = ($urandom_range(0, 3) != 0) ? 8'h3E : 8'h7A;
      for (int i = 1; i < n; i++) rom[i] = alpha[$urandom_range(0, alpha.len() - 1)];
      run($sformatf("rand%0d", r), 3000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
